// File: rtl/alu_req_scheduler.sv
// -----------------------------------------------------------------------------
// alu_req_scheduler
//   Arbitrates two requesters onto one shared, purely combinational 8-bit ALU.
//   Only one transaction is in flight at a time, and it runs IDLE -> EXEC -> RESP.
//   When both requesters are valid, a round-robin pointer picks the winner.
//   The operands are held in registers for the whole transaction. The result is
//   registered in EXEC and is presented with valid/ready in RESP.
//
//   Optional feature: define ALU_SCHED_CNT_EN to add the gnt_cnt port. It carries
//   one saturating grant counter of CNT_W bits per requester.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   req_valid/ready    per-requester handshake (ready is one-hot or zero)
//   req_a/b            packed 8-bit operands, requester i on [8i+7:8i]
//   req_op             packed 2-bit opcodes, requester i on [2i+1:2i]
//   alu_a/b/op         operands driven to the shared ALU
//   alu_y/alu_flags    ALU result and {parity, overflow, greater, is_eq, less}
//   rsp_valid/ready    response handshake
//   rsp_id/y/flags     owner index and registered result/flags
//   busy               state is not IDLE
//   gnt_cnt            grant counters (only with ALU_SCHED_CNT_EN)
// -----------------------------------------------------------------------------
module alu_req_scheduler #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [15:0]      req_a,
    input  logic [15:0]      req_b,
    input  logic [3:0]       req_op,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    output logic [1:0]       alu_op,
    input  logic [7:0]       alu_y,
    input  logic [4:0]       alu_flags,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [7:0]       rsp_y,
    output logic [4:0]       rsp_flags,
`ifdef ALU_SCHED_CNT_EN
    output logic [2*CNT_W-1:0] gnt_cnt,
`endif
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state_q, state_d;
    logic        rr_ptr_q;
    logic [7:0]  a_q, b_q;
    logic [1:0]  op_q;
    logic        id_q;
    logic [7:0]  y_q;
    logic [4:0]  flags_q;

    logic        win;
    logic        accept;

    // The round-robin pointer only matters when both requesters are valid.
    // Otherwise the single valid requester wins.
    assign win = (req_valid == 2'b11) ? rr_ptr_q : req_valid[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 2'b00;
        accept    = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                // rst_n gates ready so that no grant is shown while reset is held.
                if (rst_n && (req_valid != 2'b00)) begin
                    req_ready = win ? 2'b10 : 2'b01;
                    accept    = 1'b1;
                    state_d   = EXEC;
                end
            end
            EXEC: state_d = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            id_q     <= 1'b0;
            y_q      <= '0;
            flags_q  <= '0;
        end else begin
            if (accept) begin
                a_q      <= win ? req_a[15:8] : req_a[7:0];
                b_q      <= win ? req_b[15:8] : req_b[7:0];
                op_q     <= win ? req_op[3:2] : req_op[1:0];
                id_q     <= win;
                // The pointer moves away from the winner even if the other
                // requester was idle.
                rr_ptr_q <= ~win;
            end
            if (state_q == EXEC) begin
                y_q     <= alu_y;
                flags_q <= alu_flags;
            end
        end
    end

`ifdef ALU_SCHED_CNT_EN
    for (genvar i = 0; i < 2; i++) begin : g_cnt
        logic [CNT_W-1:0] cnt_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                cnt_q <= '0;
            else if (accept && (win == 1'(i)) && (cnt_q != {CNT_W{1'b1}}))
                cnt_q <= cnt_q + 1'b1;
        end
        assign gnt_cnt[CNT_W*i +: CNT_W] = cnt_q;
    end
`endif

    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_op    = op_q;
    assign rsp_id    = id_q;
    assign rsp_y     = y_q;
    assign rsp_flags = flags_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_req_scheduler.sv
module tb_alu_req_scheduler;

    localparam int CW = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid, req_ready;
    logic [15:0] req_a, req_b;
    logic [3:0]  req_op;
    logic [7:0]  alu_a, alu_b, alu_y;
    logic [1:0]  alu_op;
    logic [4:0]  alu_flags;
    logic        rsp_valid, rsp_ready, rsp_id, busy;
    logic [7:0]  rsp_y;
    logic [4:0]  rsp_flags;
`ifdef ALU_SCHED_CNT_EN
    logic [2*CW-1:0] gnt_cnt;
`endif

    alu_req_scheduler #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_y(alu_y), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_y(rsp_y), .rsp_flags(rsp_flags),
`ifdef ALU_SCHED_CNT_EN
        .gnt_cnt(gnt_cnt),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Shared ALU: returns {y, parity, overflow, greater, is_eq, less}
    function automatic logic [12:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                              input logic [1:0] op);
        logic [7:0] y;
        logic       ov;
        case (op)
            2'd0: begin y = a + b; ov = (a[7] == b[7]) && (y[7] != a[7]); end
            2'd1: begin y = a - b; ov = (a[7] != b[7]) && (y[7] != a[7]); end
            2'd2: begin y = a & b; ov = 1'b0; end
            default: begin y = a ^ b; ov = 1'b0; end
        endcase
        return {y, ^y, ov, a > b, a == b, a < b};
    endfunction

    assign {alu_y, alu_flags} = alu_model(alu_a, alu_b, alu_op);

    int checks = 0;
    int errors = 0;

    // reference model
    int          m_st;          // 0 idle, 1 exec, 2 resp
    logic        m_rr;
    logic [7:0]  m_a, m_b;
    logic [1:0]  m_op;
    logic [CW-1:0] m_cnt0, m_cnt1;
    logic [13:0] q[$];          // {id, y, flags}
    logic        acc_log[$];
    logic        rsp_log[$];
    int          dut_acc = 0;
    int          dut_rsp = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_rr = 1'b0; m_a = '0; m_b = '0; m_op = '0;
        m_cnt0 = '0; m_cnt1 = '0;
        q.delete();
    endtask

    task automatic zero_chk();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_y", rsp_y, 0);
        chk("rst_rsp_flags", rsp_flags, 0);
        chk("rst_busy", busy, 0);
`ifdef ALU_SCHED_CNT_EN
        chk("rst_gnt_cnt", gnt_cnt, 0);
`endif
    endtask

    // Compare DUT against the model at the negedge, then advance the model.
    task automatic check_cycle();
        logic [1:0]  exp_rdy;
        logic        w;
        logic [13:0] e;
        exp_rdy = 2'b00;
        if (rst_n && m_st == 0) begin
            case (req_valid)
                2'b01: exp_rdy = 2'b01;
                2'b10: exp_rdy = 2'b10;
                2'b11: exp_rdy = m_rr ? 2'b10 : 2'b01;
                default: exp_rdy = 2'b00;
            endcase
        end
        chk("req_ready", req_ready, exp_rdy);
        chk("busy", busy, m_st != 0);
        chk("rsp_valid", rsp_valid, m_st == 2);
        chk("alu_a", alu_a, m_a);
        chk("alu_b", alu_b, m_b);
        chk("alu_op", alu_op, m_op);
`ifdef ALU_SCHED_CNT_EN
        chk("gnt_cnt", gnt_cnt, {m_cnt1, m_cnt0});
`endif
        if (m_st == 2) begin
            if (q.size() == 0) chk("rsp_without_req", rsp_valid, 0);
            else begin
                e = q[0];
                chk("rsp_id", rsp_id, e[13]);
                chk("rsp_y", rsp_y, e[12:5]);
                chk("rsp_flags", rsp_flags, e[4:0]);
            end
        end
        // DUT-observed handshakes
        if ((req_ready & req_valid) != 2'b00) begin
            acc_log.push_back(req_ready[1]);
            dut_acc++;
        end
        if (rsp_valid && rsp_ready) begin
            rsp_log.push_back(rsp_id);
            dut_rsp++;
        end
        if (!rst_n) return;
        case (m_st)
            0: if (exp_rdy != 2'b00) begin
                w    = exp_rdy[1];
                m_a  = w ? req_a[15:8] : req_a[7:0];
                m_b  = w ? req_b[15:8] : req_b[7:0];
                m_op = w ? req_op[3:2] : req_op[1:0];
                q.push_back({w, alu_model(m_a, m_b, m_op)});
                m_rr = ~w;
                if (w) begin if (m_cnt1 != {CW{1'b1}}) m_cnt1++; end
                else   begin if (m_cnt0 != {CW{1'b1}}) m_cnt0++; end
                m_st = 1;
            end
            1: m_st = 2;
            default: if (rsp_ready) begin
                if (q.size() != 0) void'(q.pop_front());
                m_st = 0;
            end
        endcase
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        zero_chk();
        model_reset();
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        int acc0;
        req_valid = 2'b00; req_a = '0; req_b = '0; req_op = '0;
        rsp_ready = 1'b1; rst_n = 1'b0;
        model_reset();
        repeat (2) tick();
        zero_chk();
        rst_n = 1'b1;
        tick();

        // single request from requester 0
        req_valid = 2'b01; req_a = 16'h0005; req_b = 16'h0003; req_op = 4'b0000;
        tick();
        req_valid = 2'b00;
        chk("single_alu_a", alu_a, 8'h05);
        chk("single_alu_b", alu_b, 8'h03);
        chk("single_no_rsp_yet", rsp_valid, 0);
        tick();
        chk("single_rsp_valid", rsp_valid, 1);
        chk("single_rsp_y", rsp_y, 8'h08);
        tick();
        tick();
        chk("single_rsp_count", dut_rsp, 1);

        // contention from reset: both valid continuously
        req_valid = 2'b11; req_a = 16'hC87F; req_b = 16'h6401; req_op = 4'b0100;
        do_reset();
        acc_log.delete(); rsp_log.delete();
        n = 0;
        while (acc_log.size() < 4 && n < 40) begin tick(); n++; end
        req_valid = 2'b00;
        repeat (3) tick();
        chk("cont_grants", acc_log.size(), 4);
        chk("cont_rsps", rsp_log.size(), 4);
        if (acc_log.size() >= 4) begin
            chk("cont_g0", acc_log[0], 0);
            chk("cont_g1", acc_log[1], 1);
            chk("cont_g2", acc_log[2], 0);
            chk("cont_g3", acc_log[3], 1);
        end
        if (rsp_log.size() >= 4) begin
            chk("cont_r0", rsp_log[0], 0);
            chk("cont_r3", rsp_log[3], 1);
        end
`ifdef ALU_SCHED_CNT_EN
        chk("cont_gnt_cnt", gnt_cnt, {2'd2, 2'd2});
`endif

        // a requester that withdraws before grant is not served
        req_valid = 2'b01; req_a = 16'h2211; req_b = 16'h0102; req_op = 4'b1110;
        tick();
        acc0 = dut_acc;
        req_valid = 2'b10;
        tick();
        req_valid = 2'b00;
        repeat (3) tick();
        chk("withdraw_no_accept", dut_acc, acc0);

        // backpressure in RESP while requester 1 waits
        rsp_ready = 1'b0;
        req_valid = 2'b01; req_a = 16'h10AA; req_b = 16'h1055; req_op = 4'b0111;
        tick();
        req_valid = 2'b10;
        tick();
        acc0 = dut_acc;
        repeat (10) tick();
        chk("bp_no_accept", dut_acc, acc0);
        chk("bp_rsp_y", rsp_y, 8'hFF);
        rsp_ready = 1'b1;
        tick();
        chk("bp_idle_next", busy, 0);
        tick();
        req_valid = 2'b00;
        repeat (3) tick();
        chk("bp_waiter_served", dut_acc, acc0 + 1);

        // reset one cycle after accept, in EXEC
        req_valid = 2'b11; req_a = 16'h3344; req_b = 16'h1122; req_op = 4'b1000;
        tick();
        acc0 = dut_rsp;
        rst_n = 1'b0;
        #1;
        zero_chk();
        model_reset();
        repeat (2) tick();
        rst_n = 1'b1;
        #1;
        chk("post_rst_gnt", req_ready, 2'b01);
        chk("post_rst_no_rsp", rsp_valid, 0);
        tick();
        req_valid = 2'b00;
        repeat (3) tick();
        chk("post_rst_one_rsp", dut_rsp, acc0 + 1);

        // saturation on requester 1
        do_reset();
        req_valid = 2'b10; req_a = 16'h0700; req_b = 16'h0900; req_op = 4'b0100;
        acc0 = dut_acc;
        n = 0;
        while (dut_acc < acc0 + 5 && n < 60) begin tick(); n++; end
        req_valid = 2'b00;
        repeat (3) tick();
        chk("sat_grants", dut_acc, acc0 + 5);
`ifdef ALU_SCHED_CNT_EN
        chk("sat_gnt_cnt", gnt_cnt, 4'b1100);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
